// File: rtl/pipe_hold_arbiter.sv
// pipe_hold_arbiter: merges per-source hold requests with the EX jump into the
// pipeline hold level and drives the pc_reg jump. It also provides a post-jump
// flush window, a debug-halt handshake and a stall watchdog.
// Optional feature macro: HOLD_STATS_EN builds the per-source stall counters;
// without it stat_cnt_o is tied to zero.
// Hold encodings: 0 = None, 1 = Pc, 2 = If, 3 = Id.
module pipe_hold_arbiter #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned HOLD_W       = 3,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT_CYC  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*HOLD_W-1:0]   hold_lvl_i,
  input  logic                        jump_flag_i,
  input  logic [ADDR_W-1:0]           jump_addr_i,
  input  logic                        halt_req_i,
  input  logic                        timeout_clr_i,
  input  logic                        stat_clr_i,
  output logic [HOLD_W-1:0]           hold_flag_o,
  output logic                        jump_flag_o,
  output logic [ADDR_W-1:0]           jump_addr_o,
  output logic                        halt_ack_o,
  output logic                        hold_timeout_o,
  output logic [NUM_SRC*CNT_W-1:0]    stat_cnt_o
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned HC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [HOLD_W-1:0] LVL_NONE    = '0;
  localparam logic [HOLD_W-1:0] LVL_ID      = HOLD_W'(3);
  localparam logic [FC_W-1:0]   FLUSH_LOAD  = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [HC_W-1:0]   HOLD_LIMIT  = HC_W'(TIMEOUT_CYC);
  localparam bit                MULTI_FLUSH = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
  logic              halt_ack_q;
  logic [HOLD_W-1:0] src_max;
  logic [HOLD_W-1:0] fld;
  logic [HOLD_W-1:0] hold_flag_c;
  logic              enter_halt_c;
  logic              wd_set_c;

  // Deepest requested hold across all sources, out-of-range levels clamp to Id
  always_comb begin
    src_max = LVL_NONE;
    fld     = LVL_NONE;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      fld = hold_lvl_i[k*HOLD_W +: HOLD_W];
      if (fld > LVL_ID) fld = LVL_ID;
      if (fld > src_max) src_max = fld;
    end
  end

  // FSM next state, flush counter and hold level
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    hold_flag_c = src_max;
    case (state_q)
      ST_RUN: begin
        if (jump_flag_i) hold_flag_c = LVL_ID;
        if (jump_flag_i && MULTI_FLUSH) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else if (halt_req_i && !jump_flag_i) begin
          state_d = ST_HALTED;
        end
      end
      ST_FLUSH: begin
        hold_flag_c = LVL_ID;
        if (jump_flag_i) begin
          flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q == FC_W'(1)) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end
      ST_HALTED: begin
        hold_flag_c = LVL_ID;
        if (!halt_req_i) state_d = ST_RUN;
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end
    endcase
    if (rst) hold_flag_c = LVL_NONE;
  end

  // Watchdog: count consecutive non-halted hold cycles, sticky flag with clear priority
  always_comb begin
    enter_halt_c = (state_d == ST_HALTED) && (state_q != ST_HALTED);
    hold_cnt_d   = hold_cnt_q;
    if ((hold_flag_c == LVL_NONE) || enter_halt_c) begin
      hold_cnt_d = '0;
    end else if ((state_q != ST_HALTED) && (hold_cnt_q != HOLD_LIMIT)) begin
      hold_cnt_d = hold_cnt_q + HC_W'(1);
    end
    wd_set_c  = (hold_cnt_d == HOLD_LIMIT);
    timeout_d = timeout_q;
    if (timeout_clr_i)  timeout_d = 1'b0;
    else if (wd_set_c)  timeout_d = 1'b1;
  end

  // State, counters and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      halt_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
      halt_ack_q  <= (state_d == ST_HALTED);
    end
  end

  assign hold_flag_o    = hold_flag_c;
  assign jump_flag_o    = rst ? 1'b0 : jump_flag_i;
  assign jump_addr_o    = rst ? '0 : jump_addr_i;
  assign halt_ack_o     = halt_ack_q;
  assign hold_timeout_o = timeout_q;

`ifdef HOLD_STATS_EN
  logic [CNT_W-1:0] stat_q [NUM_SRC];

  // Per-source stall counters, saturating; clear beats increment
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (rst || stat_clr_i) begin
        stat_q[k] <= '0;
      end else if ((hold_lvl_i[k*HOLD_W +: HOLD_W] != LVL_NONE) &&
                   (stat_q[k] != {CNT_W{1'b1}})) begin
        stat_q[k] <= stat_q[k] + CNT_W'(1);
      end
    end
  end

  // Pack counters onto the flat output bus
  always_comb begin
    stat_cnt_o = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      stat_cnt_o[k*CNT_W +: CNT_W] = stat_q[k];
    end
  end
`else
  logic stat_unused;

  assign stat_cnt_o  = '0;
  assign stat_unused = stat_clr_i;
`endif

endmodule

// File: tb/tb_pipe_hold_arbiter.sv
// Self-checking bench for pipe_hold_arbiter (FLUSH_CYCLES=3, TIMEOUT_CYC=8).
// Inputs change 1 time unit after a rising edge, outputs are sampled 2 units later.
module tb_pipe_hold_arbiter;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned HOLD_W  = 3;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned CNT_W   = 16;
`ifdef HOLD_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic                      clk;
  logic                      rst;
  logic [NUM_SRC*HOLD_W-1:0] hold_lvl_i;
  logic                      jump_flag_i;
  logic [ADDR_W-1:0]         jump_addr_i;
  logic                      halt_req_i;
  logic                      timeout_clr_i;
  logic                      stat_clr_i;
  logic [HOLD_W-1:0]         hold_flag_o;
  logic                      jump_flag_o;
  logic [ADDR_W-1:0]         jump_addr_o;
  logic                      halt_ack_o;
  logic                      hold_timeout_o;
  logic [NUM_SRC*CNT_W-1:0]  stat_cnt_o;

  int errors = 0;
  int checks = 0;

  logic [HOLD_W-1:0] exp_hold_q [$];
  logic              exp_bit_q  [$];
  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [CNT_W-1:0]  exp_cnt_q  [$];

  pipe_hold_arbiter #(
    .NUM_SRC(NUM_SRC), .HOLD_W(HOLD_W), .ADDR_W(ADDR_W),
    .FLUSH_CYCLES(3), .TIMEOUT_CYC(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .hold_lvl_i(hold_lvl_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .halt_req_i(halt_req_i), .timeout_clr_i(timeout_clr_i),
    .stat_clr_i(stat_clr_i), .hold_flag_o(hold_flag_o),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .halt_ack_o(halt_ack_o), .hold_timeout_o(hold_timeout_o),
    .stat_cnt_o(stat_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "simulation time limit");
  end

  task automatic set_lvl(input int s0, input int s1, input int s2, input int s3);
    hold_lvl_i = {HOLD_W'(s3), HOLD_W'(s2), HOLD_W'(s1), HOLD_W'(s0)};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [HOLD_W-1:0] eh;
    logic              eb;
    logic [ADDR_W-1:0] ea;
    rst = 1'b1;
    set_lvl(3, 0, 2, 0);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hDEAD_BEEF;
    halt_req_i = 1'b0; timeout_clr_i = 1'b0; stat_clr_i = 1'b0;
    exp_hold_q.push_back('0); exp_bit_q.push_back(1'b0); exp_addr_q.push_back('0);
    #3;
    eh = exp_hold_q.pop_front(); eb = exp_bit_q.pop_front(); ea = exp_addr_q.pop_front();
    checks++; if (hold_flag_o !== eh) begin errors++; $display("FAIL reset_hold: got %0d want %0d", hold_flag_o, eh); end
    checks++; if (jump_flag_o !== eb) begin errors++; $display("FAIL reset_jump: got %0b want %0b", jump_flag_o, eb); end
    checks++; if (jump_addr_o !== ea) begin errors++; $display("FAIL reset_addr: got %h want %h", jump_addr_o, ea); end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    set_lvl(0, 0, 0, 0);
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    exp_hold_q.push_back('0); exp_bit_q.push_back(1'b0); exp_bit_q.push_back(1'b0);
    exp_cnt_q.push_back('0);
    #2;
    eh = exp_hold_q.pop_front();
    checks++; if (hold_flag_o !== eh) begin errors++; $display("FAIL idle_hold: got %0d want %0d", hold_flag_o, eh); end
    eb = exp_bit_q.pop_front();
    checks++; if (halt_ack_o !== eb) begin errors++; $display("FAIL idle_ack: got %0b want %0b", halt_ack_o, eb); end
    eb = exp_bit_q.pop_front();
    checks++; if (hold_timeout_o !== eb) begin errors++; $display("FAIL idle_timeout: got %0b want %0b", hold_timeout_o, eb); end
    eh = '0;
    if (exp_cnt_q.size() > 0) begin
      logic [CNT_W-1:0] ec;
      ec = exp_cnt_q.pop_front();
      checks++; if (stat_cnt_o !== {NUM_SRC{ec}}) begin errors++; $display("FAIL idle_stats: got %h want all %0d", stat_cnt_o, ec); end
    end
    next_cycle();
  endtask

  task automatic test_merge();
    int pat [5][4] = '{'{1,0,2,0}, '{1,0,0,0}, '{0,0,0,7}, '{5,4,0,1}, '{0,0,0,0}};
    int exp [5]    = '{2, 1, 3, 3, 0};
    logic [HOLD_W-1:0] eh;
    for (int i = 0; i < 5; i++) begin
      set_lvl(pat[i][0], pat[i][1], pat[i][2], pat[i][3]);
      exp_hold_q.push_back(HOLD_W'(exp[i]));
      #2;
      eh = exp_hold_q.pop_front();
      checks++; if (hold_flag_o !== eh) begin errors++; $display("FAIL merge[%0d]: hold_flag_o got %0d want %0d", i, hold_flag_o, eh); end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    bit jmp [10] = '{1,0,0,0, 1,0,1,0,0,0};
    int exp [10] = '{3,3,3,0, 3,3,3,3,3,0};
    logic [HOLD_W-1:0] eh;
    logic              eb;
    logic [ADDR_W-1:0] ea;
    set_lvl(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      jump_flag_i = jmp[i];
      jump_addr_i = jmp[i] ? 32'h8000_0040 + ADDR_W'(i) : '0;
      exp_hold_q.push_back(HOLD_W'(exp[i]));
      exp_bit_q.push_back(jmp[i]);
      exp_addr_q.push_back(jmp[i] ? 32'h8000_0040 + ADDR_W'(i) : '0);
      #2;
      eh = exp_hold_q.pop_front(); eb = exp_bit_q.pop_front(); ea = exp_addr_q.pop_front();
      checks++; if (hold_flag_o !== eh) begin errors++; $display("FAIL flush_hold[%0d]: got %0d want %0d", i, hold_flag_o, eh); end
      checks++; if (jump_flag_o !== eb) begin errors++; $display("FAIL flush_jump[%0d]: got %0b want %0b", i, jump_flag_o, eb); end
      checks++; if (jump_addr_o !== ea) begin errors++; $display("FAIL flush_addr[%0d]: got %h want %h", i, jump_addr_o, ea); end
      next_cycle();
    end
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
  endtask

  task automatic test_halt();
    bit jmp  [8] = '{1,0,0,0,1,0,0,0};
    bit halt [8] = '{0,1,1,1,1,0,0,0};
    int lvl  [8] = '{0,0,0,2,2,2,2,0};
    int eh_a [8] = '{3,3,3,2,3,3,2,0};
    bit ea_a [8] = '{0,0,0,0,1,1,0,0};
    logic [HOLD_W-1:0] eh;
    logic              eb;
    for (int i = 0; i < 8; i++) begin
      jump_flag_i = jmp[i];
      jump_addr_i = jmp[i] ? 32'h0000_1000 : '0;
      halt_req_i  = halt[i];
      set_lvl(0, lvl[i], 0, 0);
      exp_hold_q.push_back(HOLD_W'(eh_a[i]));
      exp_bit_q.push_back(ea_a[i]);
      exp_bit_q.push_back(jmp[i]);
      #2;
      eh = exp_hold_q.pop_front();
      checks++; if (hold_flag_o !== eh) begin errors++; $display("FAIL halt_hold[%0d]: got %0d want %0d", i, hold_flag_o, eh); end
      eb = exp_bit_q.pop_front();
      checks++; if (halt_ack_o !== eb) begin errors++; $display("FAIL halt_ack[%0d]: got %0b want %0b", i, halt_ack_o, eb); end
      eb = exp_bit_q.pop_front();
      checks++; if (jump_flag_o !== eb) begin errors++; $display("FAIL halt_jump[%0d]: got %0b want %0b", i, jump_flag_o, eb); end
      next_cycle();
    end
    jump_flag_i = 1'b0; jump_addr_i = '0; halt_req_i = 1'b0;
  endtask

  task automatic test_watchdog();
    int lvl [23] = '{1,1,1,1,1,1,1,1,1,1,0,0,0, 1,1,1,1,1,1,1,1,0,0};
    bit clr [23] = '{0,0,0,0,0,0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0,1,0,0};
    bit eto [23] = '{0,0,0,0,0,0,0,0,1,1,1,1,0, 0,0,0,0,0,0,0,0,0,0};
    logic [HOLD_W-1:0] eh;
    logic              eb;
    for (int i = 0; i < 23; i++) begin
      set_lvl(lvl[i], 0, 0, 0);
      timeout_clr_i = clr[i];
      exp_hold_q.push_back(HOLD_W'(lvl[i]));
      exp_bit_q.push_back(eto[i]);
      #2;
      eh = exp_hold_q.pop_front();
      checks++; if (hold_flag_o !== eh) begin errors++; $display("FAIL wd_hold[%0d]: got %0d want %0d", i, hold_flag_o, eh); end
      eb = exp_bit_q.pop_front();
      checks++; if (hold_timeout_o !== eb) begin errors++; $display("FAIL wd_timeout[%0d]: got %0b want %0b", i, hold_timeout_o, eb); end
      next_cycle();
    end
    timeout_clr_i = 1'b0;
  endtask

  task automatic test_stats();
    logic [CNT_W-1:0] ec;
    stat_clr_i = 1'b1;
    set_lvl(0, 0, 0, 0);
    next_cycle();
    stat_clr_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_lvl(0, 0, 1, 0);
      next_cycle();
    end
    set_lvl(0, 0, 0, 0);
    for (int k = 0; k < int'(NUM_SRC); k++)
      exp_cnt_q.push_back((STATS_ON != 0 && k == 2) ? CNT_W'(5) : CNT_W'(0));
    #2;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      ec = exp_cnt_q.pop_front();
      checks++; if (stat_cnt_o[k*CNT_W +: CNT_W] !== ec) begin errors++; $display("FAIL stats_cnt[%0d]: got %0d want %0d", k, stat_cnt_o[k*CNT_W +: CNT_W], ec); end
    end
    stat_clr_i = 1'b1;
    next_cycle();
    stat_clr_i = 1'b0;
    exp_cnt_q.push_back('0);
    #2;
    ec = exp_cnt_q.pop_front();
    checks++; if (stat_cnt_o[2*CNT_W +: CNT_W] !== ec) begin errors++; $display("FAIL stats_clr: got %0d want %0d", stat_cnt_o[2*CNT_W +: CNT_W], ec); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    bit rs   [7] = '{0,1,0,0,0,1,0};
    bit jmp  [7] = '{1,0,0,0,0,0,0};
    bit halt [7] = '{0,0,0,1,1,1,0};
    int eh_a [7] = '{3,0,0,0,3,0,0};
    bit ea_a [7] = '{0,0,0,0,1,1,0};
    logic [HOLD_W-1:0] eh;
    logic              eb;
    set_lvl(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      rst = rs[i];
      jump_flag_i = jmp[i];
      jump_addr_i = jmp[i] ? 32'h0000_2000 : '0;
      halt_req_i = halt[i];
      exp_hold_q.push_back(HOLD_W'(eh_a[i]));
      exp_bit_q.push_back(ea_a[i]);
      #2;
      eh = exp_hold_q.pop_front();
      checks++; if (hold_flag_o !== eh) begin errors++; $display("FAIL rstmid_hold[%0d]: got %0d want %0d", i, hold_flag_o, eh); end
      eb = exp_bit_q.pop_front();
      checks++; if (halt_ack_o !== eb) begin errors++; $display("FAIL rstmid_ack[%0d]: got %0b want %0b", i, halt_ack_o, eb); end
      next_cycle();
    end
    rst = 1'b0; jump_flag_i = 1'b0; halt_req_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_merge();
    test_flush();
    test_halt();
    test_watchdog();
    test_stats();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
